// File: rtl/tie_bank_cfg.sv
// -----------------------------------------------------------------------------
// tie_bank_cfg
//
// Programmable constant-drive bank. Drives NUM_CH channels of WIDTH-bit
// constants that come out of reset at a fixed tie level. New values are
// shifted in serially, then made live with a commit. A sticky lock freezes
// the outputs until the next reset.
//
// Optional build macro:
//   TIE_BANK_PARITY_EN - appends one even-parity bit after the TOTAL data
//                        bits. A commit whose parity does not match is
//                        rejected with an err pulse and forces a full reload.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   shift_valid  in   serial bit offered
//   shift_data   in   serial bit value
//   shift_ready  out  bank accepts a bit this cycle
//   commit       in   transfer shadow register to tie_out
//   lock         in   request permanent freeze
//   tie_out      out  constants; channel k = tie_out[k*WIDTH +: WIDTH]
//   locked       out  bank frozen until reset
//   err          out  one-cycle pulse after a rejected commit
//   state_dbg    out  current FSM state (IDLE=0, LOAD=1, FULL=2, LOCKED=3)
//
// Handshake: a bit is transferred on a rising edge where shift_valid and
// shift_ready are both high. shift_ready depends only on registers, so it
// never combinationally depends on shift_valid. commit and lock are
// single-cycle requests with no handshake; their outcome is reported
// through err and locked on the following cycle.
// -----------------------------------------------------------------------------
module tie_bank_cfg #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 2,
  parameter bit RESET_BIT = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      shift_valid,
  input  logic                      shift_data,
  output logic                      shift_ready,
  input  logic                      commit,
  input  logic                      lock,
  output logic [NUM_CH*WIDTH-1:0]   tie_out,
  output logic                      locked,
  output logic                      err,
  output logic [1:0]                state_dbg
);

  localparam int TOTAL = NUM_CH * WIDTH;
`ifdef TIE_BANK_PARITY_EN
  localparam int FULL_CNT = TOTAL + 1;
`else
  localparam int FULL_CNT = TOTAL;
`endif
  localparam int CW = $clog2(FULL_CNT + 1);

  localparam logic [CW-1:0] FULL_CNT_C = CW'(FULL_CNT);
  localparam logic [CW-1:0] LAST_CNT_C = CW'(FULL_CNT - 1);
  localparam logic [CW-1:0] TOTAL_C    = CW'(TOTAL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FULL   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t            state;
  logic [TOTAL-1:0]  sh;
  logic [CW-1:0]     cnt;
  logic              shift_acc;
  logic              parity_ok;

`ifdef TIE_BANK_PARITY_EN
  logic par_q;
  // Even parity: the parity bit equals the XOR of all data bits.
  assign parity_ok = ((^sh) == par_q);
`else
  assign parity_ok = 1'b1;
`endif

  assign shift_ready = !locked && (cnt != FULL_CNT_C);
  assign shift_acc   = shift_valid && shift_ready;
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sh      <= '0;
      cnt     <= '0;
      tie_out <= {TOTAL{RESET_BIT}};
      locked  <= 1'b0;
      err     <= 1'b0;
`ifdef TIE_BANK_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      err <= 1'b0;
      if (state == LOCKED) begin
        // Frozen: only a commit has a visible effect, and it is rejected.
        if (commit) err <= 1'b1;
      end else begin
        if (shift_acc) begin
          // Data bits enter at the MSB so the first bit ends up in sh[0];
          // with parity enabled the extra trailing bit goes to par_q.
          if (cnt < TOTAL_C) begin
            sh <= {shift_data, sh[TOTAL-1:1]};
          end
`ifdef TIE_BANK_PARITY_EN
          else begin
            par_q <= shift_data;
          end
`endif
          cnt <= cnt + CW'(1);
        end

        if (commit) begin
          if (state == FULL) begin
            // A bad-parity commit still empties the counter so the whole
            // word, not just the parity bit, must be resent.
            cnt <= '0;
            if (parity_ok) tie_out <= sh;
            else           err     <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end

        // In FULL shift_ready is low, so a commit never races a shift here.
        if (lock) begin
          state  <= LOCKED;
          locked <= 1'b1;
        end else if (commit && (state == FULL)) begin
          state <= IDLE;
        end else if (shift_acc) begin
          state <= (cnt == LAST_CNT_C) ? FULL : LOAD;
        end
      end
    end
  end

endmodule
